// File: rtl/vecreduce_if.sv
// Handshake and data bundle for the vector-to-scalar reduction unit.
// The master side issues requests; the slave side (the unit) returns the scalar and flags.
interface vecreduce_if;
    logic         start;
    logic [2:0]   op;
    logic [159:0] vr;
    logic         busy;
    logic         done;
    logic [31:0]  result;
    logic [3:0]   ALUFlags;

    modport master (output start, op, vr, input busy, done, result, ALUFlags);
    modport slave  (input start, op, vr, output busy, done, result, ALUFlags);
endinterface

// File: rtl/vecreduce.sv
// Sequential five-element vector reduction.
// Folds one element per clock and reports the scalar result with NZCV flags from the last fold.
module vecreduce (
    input  logic        clk,
    input  logic        reset,
    vecreduce_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [31:0]    acc_q, acc_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     op_q, op_d;
    logic [159:0]   vr_q, vr_d;
    logic [31:0]    result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           done_q, done_d;

    logic [4:0][31:0] elems;
    logic [31:0]    el;
    logic [32:0]    sum, diff;
    logic [31:0]    fold;
    logic           fold_c, fold_v;

    assign elems = vr_q;
    assign el    = elems[idx_q];
    assign sum   = {1'b0, acc_q} + {1'b0, el};
    assign diff  = {1'b0, acc_q} - {1'b0, el};

    // Pass ops leave acc untouched, so it still holds element 0 at completion.
    always_comb begin
        fold   = acc_q;
        fold_c = 1'b0;
        fold_v = 1'b0;
        if (!op_q[2]) begin
            case (op_q[1:0])
                2'b00: begin
                    fold   = sum[31:0];
                    fold_c = sum[32];
                    fold_v = (acc_q[31] == el[31]) && (sum[31] != acc_q[31]);
                end
                2'b01: begin
                    fold   = diff[31:0];
                    fold_c = ~diff[32];
                    fold_v = (acc_q[31] != el[31]) && (diff[31] != acc_q[31]);
                end
                2'b10:   fold = acc_q & el;
                default: fold = acc_q | el;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        op_d     = op_q;
        vr_d     = vr_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vr_d    = bus.vr;
                    op_d    = bus.op;
                    acc_d   = bus.vr[31:0];
                    idx_d   = 3'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = fold;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd4) begin
                    result_d = fold;
                    flags_d  = {fold[31], fold == 32'd0, fold_c, fold_v};
                    done_d   = 1'b1;
                    idx_d    = 3'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            op_q     <= '0;
            vr_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            vr_q     <= vr_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_vecreduce.sv
// Scoreboard bench for vecreduce: stimulus pushes reference results, a monitor pops on done.
// Reference model works on plain integer arithmetic over the element list.
module tb_vecreduce;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [35:0] exp_q[$];

    vecreduce_if bus();

    vecreduce dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [159:0] pack(input logic [31:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [159:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Returns {N,Z,C,V,result}.
    function automatic logic [35:0] model(input logic [159:0] v, input logic [2:0] o);
        logic [31:0] e [5];
        logic [31:0] acc, r;
        longint unsigned ua;
        longint sa;
        logic c, vf;
        for (int i = 0; i < 5; i++) e[i] = v[32*i +: 32];
        if (o[2]) return {e[0][31], e[0] == 32'd0, 2'b00, e[0]};
        acc = e[0];
        for (int i = 1; i < 4; i++) begin
            case (o[1:0])
                2'd0:    acc = acc + e[i];
                2'd1:    acc = acc - e[i];
                2'd2:    acc = acc & e[i];
                default: acc = acc | e[i];
            endcase
        end
        c = 1'b0;
        vf = 1'b0;
        case (o[1:0])
            2'd0: begin
                ua = {32'd0, acc} + {32'd0, e[4]};
                r  = ua[31:0];
                c  = ua > 64'h0000_0000_FFFF_FFFF;
                sa = longint'($signed(acc)) + longint'($signed(e[4]));
                vf = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
            end
            2'd1: begin
                r  = acc - e[4];
                c  = acc >= e[4];
                sa = longint'($signed(acc)) - longint'($signed(e[4]));
                vf = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
            end
            2'd2:    r = acc & e[4];
            default: r = acc | e[4];
        endcase
        return {r[31], r == 32'd0, c, vf, r};
    endfunction

    // Monitor: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.busy && bus.done) chk("busy_and_done", 1, 0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    chk("result", {32'd0, bus.result}, {32'd0, e[31:0]});
                    chk("flags", {60'd0, bus.ALUFlags}, {60'd0, e[35:32]});
                end
            end
        end
    end

    // Call at a negedge; returns just after the start-capture edge with junk on vr/op.
    task automatic kick(input logic [159:0] v, input logic [2:0] o);
        bus.start = 1'b1;
        bus.vr    = v;
        bus.op    = o;
        exp_q.push_back(model(v, o));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.vr    = rnd_vec();
        bus.op    = 3'($urandom);
    endtask

    // Call at a negedge; returns at the negedge of the done cycle.
    task automatic run_check(input logic [159:0] v, input logic [2:0] o, input bit poke);
        kick(v, o);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (poke && c == 2) begin
                bus.start = 1'b1;
                bus.vr    = rnd_vec();
            end
            if (poke && c == 3) bus.start = 1'b0;
            chk("busy_window", {63'd0, bus.busy}, 64'd1);
        end
        @(negedge clk);
        chk("done_pulse", {63'd0, bus.done}, 64'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.vr    = '0;
        #2;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_flags", {60'd0, bus.ALUFlags}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_check(pack(1, 2, 3, 4, 5), 3'b000, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
        run_check(pack(10, 1, 2, 3, 4), 3'b001, 1'b0);
        run_check(pack(32'h7FFF_FFFF, 0, 0, 0, 1), 3'b000, 1'b0);
        run_check(pack(32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFFF_0000, 32'h8000_0000), 3'b010, 1'b0);
        run_check(pack(32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFFF_0000, 32'h8000_0000), 3'b011, 1'b0);
        run_check(pack(0, 7, 8, 9, 10), 3'b100, 1'b0);

        // Ignored start while busy, then back-to-back from the done cycle.
        run_check(pack(3, 3, 3, 3, 3), 3'b000, 1'b1);
        run_check(pack(5, 5, 5, 5, 5), 3'b000, 1'b0);
        repeat (6) @(negedge clk);
        chk("idle_after_b2b", {63'd0, bus.busy}, 64'd0);

        // Abort mid-run: outputs clear without a clock edge.
        kick(pack(9, 9, 9, 9, 9), 3'b000);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_result", {32'd0, bus.result}, 64'd0);
        chk("abort_flags", {60'd0, bus.ALUFlags}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        run_check(pack(1, 2, 3, 4, 5), 3'b000, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run_check(rnd_vec(), 3'($urandom), 1'($urandom));
        end

        repeat (8) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
